// File: rtl/seq_divider64_pkg.sv
// Shared definitions for the sequential divider.
//   - DefaultWidth / DefaultCntW: operand width and iteration counter width defaults
//   - DivZeroQuot: quotient reported when the divisor is zero
//   - state_e: FSM encoding (2'b11 is illegal and recovers to idle)
package seq_divider64_pkg;

  localparam int unsigned DefaultWidth = 64;
  localparam int unsigned DefaultCntW  = 7;

  localparam logic [DefaultWidth-1:0] DivZeroQuot = '1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/seq_divider64_if.sv
// Handshake and operand/result bundle for seq_divider64.
//   master: drives op_start, op_clear, dividend, divisor; reads results
//   slave : the divider; drives quotient, remainder, done, busy, div_by_zero
interface seq_divider64_if #(
  parameter int unsigned WIDTH = 64
);
  logic             op_start;
  logic             op_clear;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output op_start, op_clear, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  op_start, op_clear, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/seq_divider64_sub65.sv
// (WIDTH+1)-bit subtractor: o_diff = i_a - i_b computed as i_a + ~i_b + 1.
// Built from 4-bit carry-lookahead groups rippling group to group, plus one
// full-adder bit on top. WIDTH must be a multiple of 4.
//   i_a, i_b : minuend / subtrahend (WIDTH+1 bits)
//   o_diff   : difference (WIDTH+1 bits)
//   o_co     : carry out, 1 means no borrow (i_a >= i_b)
module seq_divider64_sub65 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_co
);

  localparam int unsigned NumGroups = WIDTH / 4;

  logic [WIDTH:0] w_bn;
  logic [3:0]     w_g;
  logic [3:0]     w_p;
  logic [4:0]     w_cc;
  logic           w_c;

  assign w_bn = ~i_b;

  // Group carries are resolved inside one process so the ripple between groups
  // is not seen as a combinational loop on a shared vector.
  always_comb begin
    w_g    = '0;
    w_p    = '0;
    w_cc   = '0;
    w_c    = 1'b1;  // +1 of the two's-complement negate
    o_diff = '0;
    o_co   = 1'b0;
    for (int g = 0; g < NumGroups; g++) begin
      w_g     = i_a[4*g +: 4] & w_bn[4*g +: 4];
      w_p     = i_a[4*g +: 4] ^ w_bn[4*g +: 4];
      w_cc[0] = w_c;
      w_cc[1] = w_g[0] | (w_p[0] & w_c);
      w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c);
      w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & w_c);
      w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c);
      o_diff[4*g +: 4] = w_p ^ w_cc[3:0];
      w_c = w_cc[4];
    end
    o_diff[WIDTH] = i_a[WIDTH] ^ w_bn[WIDTH] ^ w_c;
    o_co          = (i_a[WIDTH] & w_bn[WIDTH]) | (i_a[WIDTH] & w_c) | (w_bn[WIDTH] & w_c);
  end

endmodule

// File: rtl/seq_divider64.sv
// Multicycle restoring divider, one quotient bit per cycle.
// Optional macro DIV_SIGNED_EN: two's-complement operands with a sign fix-up
// cycle before done; undefined gives a purely unsigned divider.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : seq_divider64_if slave (start/clear, operands, results, done/busy/dbz)
// Result latency after the accepting edge T: done from T+WIDTH+1 (T+WIDTH+2 signed),
// T+1 for a zero divisor.
module seq_divider64
  import seq_divider64_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  seq_divider64_if.slave        bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_busy;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic             w_co;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_unused_r_msb;

`ifdef DIV_SIGNED_EN
  logic r_sq;
  logic r_sr;
  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dvs_mag = bus.divisor;
`endif

  // Partial remainder stays below the divisor, so its top bit only matters
  // inside the trial subtraction.
  assign w_unused_r_msb = r_r[WIDTH];

  assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  seq_divider64_sub65 #(
    .WIDTH (WIDTH)
  ) u_sub (
    .i_a    (w_rs),
    .i_b    ({1'b0, r_d}),
    .o_diff (w_diff),
    .o_co   (w_co)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.op_clear) begin
      r_state       <= StIdle;
      r_q           <= '0;
      r_d           <= '0;
      r_r           <= '0;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_sq          <= 1'b0;
      r_sr          <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.op_start) begin
            r_cnt <= '0;
            if (bus.divisor == '0) begin
              r_q     <= WIDTH'(DivZeroQuot);
              r_r     <= {1'b0, bus.dividend};
              r_d     <= '0;
              r_dz    <= 1'b1;
              r_state <= StDone;
            end else begin
              r_q     <= w_dvd_mag;
              r_d     <= w_dvs_mag;
              r_r     <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= StExec;
`ifdef DIV_SIGNED_EN
              r_sq    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_sr    <= bus.dividend[WIDTH-1];
`endif
            end
          end
        end
        StExec: begin
`ifdef DIV_SIGNED_EN
          if (r_cnt == CNT_W'(WIDTH)) begin
            // Extra cycle after the last iteration applies the result signs.
            r_q     <= r_sq ? (~r_q + 1'b1) : r_q;
            r_r     <= r_sr ? (~r_r + 1'b1) : r_r;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_r   <= w_co ? w_diff : w_rs;
            r_q   <= {r_q[WIDTH-2:0], w_co};
            r_cnt <= r_cnt + 1'b1;
          end
`else
          r_r   <= w_co ? w_diff : w_rs;
          r_q   <= {r_q[WIDTH-2:0], w_co};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StDone;
          end
`endif
        end
        StDone: begin
          // Outputs load once on entry and then hold until clear/reset.
          if (!r_done) begin
            r_quotient    <= r_q;
            r_remainder   <= r_r[WIDTH-1:0];
            r_div_by_zero <= r_dz;
            r_done        <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider64.sv
module tb_seq_divider64;

`ifdef DIV_SIGNED_EN
  localparam int ExpLat = 66;
`else
  localparam int ExpLat = 65;
`endif
  localparam int MaxWait = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_divider64_if #(.WIDTH(64)) bus ();

  seq_divider64 #(
    .WIDTH (64),
    .CNT_W (7)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int k;
    lat = MaxWait;
    k = 1;
    while (k <= MaxWait) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        k = MaxWait + 1;
      end else begin
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.quotient !== 64'd0) begin errors++;
      $display("FAIL reset_quotient got %h want 0", bus.quotient); end
    checks++; if (bus.remainder !== 64'd0) begin errors++;
      $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    checks++; if (bus.done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++;
      $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    start_op(64'd1000, 64'd3);
    repeat (30) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL midexec_busy got %b want 1", bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({bus.done, bus.busy, bus.div_by_zero} !== 3'b000) begin errors++;
      $display("FAIL midexec_reset_flags got %b want 000", {bus.done, bus.busy, bus.div_by_zero}); end
    checks++; if ({bus.quotient, bus.remainder} !== 128'd0) begin errors++;
      $display("FAIL midexec_reset_data got %h %h want 0 0", bus.quotient, bus.remainder); end
    start_op(64'd1000, 64'd3);
    wait_done(lat);
    checks++; if (lat !== ExpLat) begin errors++;
      $display("FAIL fresh_latency got %0d want %0d", lat, ExpLat); end
    checks++; if (bus.quotient !== 64'd333 || bus.remainder !== 64'd1) begin errors++;
      $display("FAIL fresh_result got q=%0d r=%0d want q=333 r=1", bus.quotient, bus.remainder); end
    bus.op_clear = 1'b1; tick(); bus.op_clear = 1'b0;
  endtask

  task automatic test_divide(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] eq, input logic [63:0] er,
                             input logic edz, input int elat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    checks++; if (lat !== elat) begin errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, elat); end
    checks++; if (bus.quotient !== eq) begin errors++;
      $display("FAIL %s_quotient got %h want %h", name, bus.quotient, eq); end
    checks++; if (bus.remainder !== er) begin errors++;
      $display("FAIL %s_remainder got %h want %h", name, bus.remainder, er); end
    checks++; if (bus.div_by_zero !== edz || bus.busy !== 1'b0) begin errors++;
      $display("FAIL %s_flags got dbz=%b busy=%b want dbz=%b busy=0", name,
               bus.div_by_zero, bus.busy, edz); end
    bus.op_clear = 1'b1; tick(); bus.op_clear = 1'b0;
  endtask

  task automatic test_start_ignored();
    int lat;
    start_op(64'd100, 64'd7);
    repeat (9) tick();
    bus.dividend = 64'd50;
    bus.divisor  = 64'd5;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    wait_done(lat);
    checks++; if (lat !== ExpLat - 10) begin errors++;
      $display("FAIL ignored_latency got %0d want %0d", lat, ExpLat - 10); end
    checks++; if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin errors++;
      $display("FAIL ignored_result got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder); end
    bus.dividend = 64'd9;
    bus.divisor  = 64'd0;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.quotient !== 64'd14 || bus.div_by_zero !== 1'b0)
      begin errors++;
      $display("FAIL done_hold got done=%b q=%0d dbz=%b want done=1 q=14 dbz=0",
               bus.done, bus.quotient, bus.div_by_zero); end
    bus.op_clear = 1'b1; tick(); bus.op_clear = 1'b0;
    checks++; if ({bus.done, bus.quotient, bus.remainder} !== 129'd0) begin errors++;
      $display("FAIL done_clear got done=%b q=%h r=%h want all 0",
               bus.done, bus.quotient, bus.remainder); end
  endtask

  task automatic test_clear_exec();
    logic seen;
    start_op(64'd100, 64'd7);
    repeat (39) tick();
    bus.op_clear = 1'b1;
    tick();
    bus.op_clear = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL exec_clear got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL exec_clear_quiet got activity=%b want 0", seen); end
  endtask

  task automatic test_start_clear_idle();
    bus.dividend = 64'd100;
    bus.divisor  = 64'd7;
    bus.op_start = 1'b1;
    bus.op_clear = 1'b1;
    tick();
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL start_clear_busy got %b want 0", bus.busy); end
    repeat (70) tick();
    checks++; if (bus.done !== 1'b0) begin errors++;
      $display("FAIL start_clear_done got %b want 0", bus.done); end
  endtask

  initial begin
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_reset_mid_exec();
    test_divide("d100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, ExpLat);
    test_divide("max_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, ExpLat);
    test_divide("d5_9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, ExpLat);
    test_divide("divzero", 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
`ifdef DIV_SIGNED_EN
    test_divide("neg100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, ExpLat);
    test_divide("min_neg1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 64'd0, 1'b0, ExpLat);
`else
    test_divide("big_2p32", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
                64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, ExpLat);
    test_divide("msb_3", 64'h8000_0000_0000_0000, 64'd3,
                64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, ExpLat);
`endif
    test_start_ignored();
    test_clear_exec();
    test_start_clear_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
